// File: rtl/me_refwin_pkg.sv
// Shared types, derived constants and parameter legality helpers for the
// reference-window shift-chain scheduler.
package me_refwin_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SHIFT,
        ST_DONE
    } refwin_state_e;

    localparam int DEF_PIX_W    = 8;
    localparam int DEF_WORD_PIX = 7;
    localparam int DEF_WIN_W    = 56;
    localparam int DEF_WIN_H    = 64;
    localparam int DEF_ADDR_W   = 12;

    localparam int WORDS_PER_ROW = DEF_WIN_W / DEF_WORD_PIX;

    function automatic int words_per_row(input int win_w, input int word_pix);
        return win_w / word_pix;
    endfunction

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit cfg_ok(input int pix_w, input int word_pix, input int win_w,
                                  input int win_h, input int addr_w);
        longint last_addr;
        if (pix_w < 1 || word_pix < 1 || win_w < 1 || win_h < 1 || addr_w < 1) return 1'b0;
        if (win_w % word_pix != 0) return 1'b0;
        last_addr = longint'(win_h) * longint'(win_w / word_pix) - 1;
        return last_addr < (longint'(1) << addr_w);
    endfunction

endpackage

// File: rtl/me_refwin_sched_sat_counter.sv
// me_sat_counter: saturating up-counter with synchronous clear and enable.
module me_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk_i) begin
        if (!rstn_i || clr_i) begin
            cnt_reg <= '0;
        end else if (en_i && (cnt_reg != {W{1'b1}})) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign cnt_o = cnt_reg;

endmodule

// File: rtl/me_refwin_sched.sv
// Reference-window shift-chain scheduler: one word fetch per WORD_PIX pixels,
// one pixel into the chain per active cycle. Optional ME_REFWIN_PERF_EN adds counters.
module me_refwin_sched
    import me_refwin_pkg::*;
#(
    parameter int PIX_W    = DEF_PIX_W,
    parameter int WORD_PIX = DEF_WORD_PIX,
    parameter int WIN_W    = DEF_WIN_W,
    parameter int WIN_H    = DEF_WIN_H,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      start_i,
    input  logic                      stall_i,
    output logic                      mem_req_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    output logic                      load_o,
    output logic                      shift_o,
    output logic                      pix_valid_o,
    output logic [idx_w(WIN_H)-1:0]   row_o,
    output logic [idx_w(WIN_W)-1:0]   col_o,
    output logic                      busy_o,
`ifdef ME_REFWIN_PERF_EN
    output logic [31:0]               stall_cnt_o,
    output logic [31:0]               wait_cnt_o,
`endif
    output logic                      done_o
);

    localparam int WPR    = words_per_row(WIN_W, WORD_PIX);
    localparam int ROW_W  = idx_w(WIN_H);
    localparam int COL_W  = idx_w(WIN_W);
    localparam int PIX_IW = idx_w(WORD_PIX);
    localparam int WRD_W  = idx_w(WPR);

    localparam logic [PIX_IW-1:0] PIX_LAST  = PIX_IW'(WORD_PIX - 1);
    localparam logic [WRD_W-1:0]  WORD_LAST = WRD_W'(WPR - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(WIN_H - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIN_W - 1);

    if (!cfg_ok(PIX_W, WORD_PIX, WIN_W, WIN_H, ADDR_W)) begin : g_cfg_err
        $error("me_refwin_sched: illegal window/word/address parameter set");
    end

    refwin_state_e      state_reg, state_next;
    logic [PIX_IW-1:0]  pix_reg;
    logic [WRD_W-1:0]   word_reg;
    logic [ROW_W-1:0]   row_reg;
    logic [ROW_W-1:0]   row_last_reg;
    logic [COL_W-1:0]   col_nxt_reg;
    logic [COL_W-1:0]   col_last_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic               eow;
    logic               last_word;
    logic               last_row;
    logic               start_acc;

    assign last_word = (word_reg == WORD_LAST);
    assign last_row  = (row_reg == ROW_LAST);
    assign start_acc = (state_reg == ST_IDLE) && start_i;

    always_comb begin
        state_next  = state_reg;
        mem_req_o   = 1'b0;
        load_o      = 1'b0;
        shift_o     = 1'b0;
        pix_valid_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        eow         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_i) state_next = ST_REQ;
            end
            ST_REQ: begin
                busy_o    = 1'b1;
                mem_req_o = 1'b1;
                if (mem_gnt_i) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                busy_o = 1'b1;
                if (mem_rvalid_i) begin
                    load_o      = 1'b1;
                    pix_valid_o = 1'b1;
                    if (WORD_PIX == 1) eow = 1'b1;
                    else               state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy_o = 1'b1;
                if (!stall_i) begin
                    shift_o     = 1'b1;
                    pix_valid_o = 1'b1;
                    if (pix_reg == PIX_LAST) eow = 1'b1;
                end
            end
            ST_DONE: begin
                done_o     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (eow) state_next = (last_word && last_row) ? ST_DONE : ST_REQ;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_reg    <= ST_IDLE;
            pix_reg      <= '0;
            word_reg     <= '0;
            row_reg      <= '0;
            row_last_reg <= '0;
            col_nxt_reg  <= '0;
            col_last_reg <= '0;
            addr_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (start_acc) begin
                pix_reg      <= '0;
                word_reg     <= '0;
                row_reg      <= '0;
                row_last_reg <= '0;
                col_nxt_reg  <= '0;
                col_last_reg <= '0;
                addr_reg     <= '0;
            end
            if (load_o)       pix_reg <= PIX_IW'(1);
            else if (shift_o) pix_reg <= pix_reg + PIX_IW'(1);
            // The last-valid copies let row_o/col_o hold between pixels.
            if (pix_valid_o) begin
                row_last_reg <= row_reg;
                col_last_reg <= col_nxt_reg;
                col_nxt_reg  <= (col_nxt_reg == COL_LAST) ? '0 : col_nxt_reg + COL_W'(1);
            end
            if (eow && !(last_word && last_row)) begin
                addr_reg <= addr_reg + ADDR_W'(1);
                if (last_word) begin
                    word_reg <= '0;
                    row_reg  <= row_reg + ROW_W'(1);
                end else begin
                    word_reg <= word_reg + WRD_W'(1);
                end
            end
        end
    end

    assign mem_addr_o = addr_reg;
    assign row_o      = pix_valid_o ? row_reg     : row_last_reg;
    assign col_o      = pix_valid_o ? col_nxt_reg : col_last_reg;

`ifdef ME_REFWIN_PERF_EN
    logic stall_en;
    logic wait_en;
    assign stall_en = (state_reg == ST_SHIFT) && stall_i;
    assign wait_en  = (state_reg == ST_REQ) || ((state_reg == ST_WAIT) && !mem_rvalid_i);

    me_sat_counter #(.W(32)) u_stall_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (start_acc),
        .en_i   (stall_en),
        .cnt_o  (stall_cnt_o)
    );

    me_sat_counter #(.W(32)) u_wait_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (start_acc),
        .en_i   (wait_en),
        .cnt_o  (wait_cnt_o)
    );
`endif

endmodule

// File: tb/tb_me_refwin_sched.sv
// Bench for me_refwin_sched: a cycle timeline is derived arithmetically from a
// per-word delay/stall schedule, then every cycle of the DUT is compared to it.
module tb_me_refwin_sched;

    localparam int MAXC = 256;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start_a = 1'b0, start_d = 1'b0;
    logic stall = 1'b0, gnt = 1'b0, rv = 1'b0;

    logic       a_req, a_load, a_shift, a_pv, a_busy, a_done;
    logic [3:0] a_addr;
    logic [0:0] a_row;
    logic [3:0] a_col;
    logic       d_req, d_load, d_shift, d_pv, d_busy, d_done;
    logic [3:0] d_addr;
    logic [0:0] d_row;
    logic [1:0] d_col;
`ifdef ME_REFWIN_PERF_EN
    logic [31:0] a_stall_cnt, a_wait_cnt, d_stall_cnt, d_wait_cnt;
`endif

    always #5 clk = ~clk;

    me_refwin_sched #(.PIX_W(8), .WORD_PIX(7), .WIN_W(14), .WIN_H(2), .ADDR_W(4)) u_dut_a (
        .clk_i(clk), .rstn_i(rstn), .start_i(start_a), .stall_i(stall),
        .mem_req_o(a_req), .mem_addr_o(a_addr), .mem_gnt_i(gnt), .mem_rvalid_i(rv),
        .load_o(a_load), .shift_o(a_shift), .pix_valid_o(a_pv),
        .row_o(a_row), .col_o(a_col), .busy_o(a_busy),
`ifdef ME_REFWIN_PERF_EN
        .stall_cnt_o(a_stall_cnt), .wait_cnt_o(a_wait_cnt),
`endif
        .done_o(a_done)
    );

    me_refwin_sched #(.PIX_W(8), .WORD_PIX(1), .WIN_W(4), .WIN_H(1), .ADDR_W(4)) u_dut_d (
        .clk_i(clk), .rstn_i(rstn), .start_i(start_d), .stall_i(stall),
        .mem_req_o(d_req), .mem_addr_o(d_addr), .mem_gnt_i(gnt), .mem_rvalid_i(rv),
        .load_o(d_load), .shift_o(d_shift), .pix_valid_o(d_pv),
        .row_o(d_row), .col_o(d_col), .busy_o(d_busy),
`ifdef ME_REFWIN_PERF_EN
        .stall_cnt_o(d_stall_cnt), .wait_cnt_o(d_wait_cnt),
`endif
        .done_o(d_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected control vector bits: {req, load, shift, pix_valid, busy, done}
    logic [5:0] exp_v   [MAXC];
    int         exp_addr[MAXC];
    int         exp_row [MAXC];
    int         exp_col [MAXC];
    bit         stall_a [MAXC];
    bit         gnt_a   [MAXC];
    bit         rv_a    [MAXC];
    bit         st_a    [MAXC];
    int         end_c;
    int         exp_stall_sum, exp_wait_sum;
    int         r_loads, r_shifts, r_pvs, r_dones, r_done_cyc, r_req2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Builds the expected timeline: per word, REQ for g+1 cycles (grant in the
    // last), r idle WAIT cycles, a load, then WORD_PIX-1 shifts each preceded by
    // s stall cycles. done follows the final pixel.
    task automatic build(input int wp, input int ww, input int wh, input bit rnd,
                         input int sw, input int sl, input int gw, input int gd);
        int c, words, k, g, r, s;
        for (int i = 0; i < MAXC; i++) begin
            exp_v[i] = '0; exp_addr[i] = 0; exp_row[i] = 0; exp_col[i] = 0;
            stall_a[i] = 0; gnt_a[i] = 0; rv_a[i] = 0; st_a[i] = 0;
        end
        words = ww * wh / wp;
        c = 1;
        exp_stall_sum = 0;
        exp_wait_sum  = 0;
        for (int w = 0; w < words; w++) begin
            g = rnd ? int'($urandom_range(0, 3)) : ((w == gw) ? gd : 0);
            r = rnd ? int'($urandom_range(0, 2)) : 0;
            for (int i = 0; i <= g; i++) begin
                exp_v[c] = 6'b100010; exp_addr[c] = w;
                if (rnd) begin
                    stall_a[c] = bit'($urandom_range(0, 1));
                    rv_a[c]    = ($urandom_range(0, 3) == 0);
                end
                c++;
            end
            gnt_a[c-1] = 1;
            for (int i = 0; i < r; i++) begin
                exp_v[c] = 6'b000010;
                if (rnd) stall_a[c] = bit'($urandom_range(0, 1));
                c++;
            end
            exp_wait_sum += g + 1 + r;
            k = w * wp;
            rv_a[c] = 1; exp_v[c] = 6'b010110;
            exp_row[c] = k / ww; exp_col[c] = k % ww;
            if (rnd) stall_a[c] = bit'($urandom_range(0, 1));
            for (int j = 1; j < wp; j++) begin
                if (rnd) s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                else     s = (w == sw && j == 3) ? sl : 0;
                for (int i = 0; i < s; i++) begin
                    c++; exp_v[c] = 6'b000010; stall_a[c] = 1;
                    if (rnd) rv_a[c] = bit'($urandom_range(0, 1));
                end
                exp_stall_sum += s;
                c++; exp_v[c] = 6'b001110;
                exp_row[c] = (k + j) / ww; exp_col[c] = (k + j) % ww;
                if (rnd) rv_a[c] = bit'($urandom_range(0, 1));
            end
            c++;
        end
        exp_v[c] = 6'b000001;
        end_c = c;
        if (rnd) for (int i = 2; i < end_c; i++) st_a[i] = ($urandom_range(0, 7) == 0);
    endtask

    task automatic sample(input bit sel, output logic [5:0] ov, output int oa,
                          output int orow, output int ocol);
        if (sel) begin
            ov = {d_req, d_load, d_shift, d_pv, d_busy, d_done};
            oa = int'(d_addr); orow = int'(d_row); ocol = int'(d_col);
        end else begin
            ov = {a_req, a_load, a_shift, a_pv, a_busy, a_done};
            oa = int'(a_addr); orow = int'(a_row); ocol = int'(a_col);
        end
    endtask

    // Entered and left just after a rising edge. abort_c >= 0 pulls reset low
    // in that cycle and stops checking from it onwards.
    task automatic run_scan(input bit sel, input int abort_c, input string name);
        logic [5:0] ov;
        int oa, orow, ocol;
        r_loads = 0; r_shifts = 0; r_pvs = 0; r_dones = 0; r_done_cyc = -1; r_req2 = 0;
        for (int c = 0; c <= end_c + 1; c++) begin
            start_a = !sel && (c == 0 || st_a[c]);
            start_d = sel && (c == 0 || st_a[c]);
            stall = stall_a[c]; gnt = gnt_a[c]; rv = rv_a[c];
            rstn  = (c != abort_c);
            @(negedge clk);
            if (abort_c < 0 || c < abort_c) begin
                sample(sel, ov, oa, orow, ocol);
                check($sformatf("%s ctl c%0d", name, c), 64'(ov), 64'(exp_v[c]));
                if (exp_v[c][5]) check($sformatf("%s addr c%0d", name, c), 64'(oa), 64'(exp_addr[c]));
                if (exp_v[c][2]) begin
                    check($sformatf("%s row c%0d", name, c), 64'(orow), 64'(exp_row[c]));
                    check($sformatf("%s col c%0d", name, c), 64'(ocol), 64'(exp_col[c]));
                end
                r_loads  += int'(ov[4]);
                r_shifts += int'(ov[3]);
                r_pvs    += int'(ov[2]);
                if (ov[0] === 1'b1) begin
                    r_dones++;
                    if (r_done_cyc < 0) r_done_cyc = c;
                end
                if (ov[5] === 1'b1 && oa == 2) r_req2++;
            end
            @(posedge clk); #1;
            if (c == abort_c) break;
        end
        start_a = 0; start_d = 0; stall = 0; gnt = 0; rv = 0; rstn = 1;
        $display("scan %s: done_cycle=%0d loads=%0d shifts=%0d pix=%0d dones=%0d",
                 name, r_done_cyc, r_loads, r_shifts, r_pvs, r_dones);
    endtask

    task automatic check_perf(input bit sel, input string name);
`ifdef ME_REFWIN_PERF_EN
        check({name, " stall_cnt"}, 64'(sel ? d_stall_cnt : a_stall_cnt), 64'(exp_stall_sum));
        check({name, " wait_cnt"},  64'(sel ? d_wait_cnt  : a_wait_cnt),  64'(exp_wait_sum));
`else
        if (name.len() == 0) $display("perf counters absent");
`endif
    endtask

    initial begin
        logic [5:0] ov;
        int oa, orow, ocol;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        sample(1'b0, ov, oa, orow, ocol);
        check("reset ctl", 64'(ov), 64'(0));
        check("reset addr/row/col", 64'({oa, orow, ocol}), 64'(0));
        @(posedge clk); #1;
        rstn = 1;
        @(posedge clk); #1;

        // Nominal frame, minimum latency, no stall.
        build(7, 14, 2, 1'b0, -1, 0, -1, 0);
        run_scan(1'b0, -1, "nominal");
        check("nominal done cycle", 64'(r_done_cyc), 64'(33));
        check("nominal loads",      64'(r_loads),    64'(4));
        check("nominal shifts",     64'(r_shifts),   64'(24));
        check("nominal pixels",     64'(r_pvs),      64'(28));
        check_perf(1'b0, "nominal");

        // Five-cycle stall in the middle of word 1.
        build(7, 14, 2, 1'b0, 1, 5, -1, 0);
        run_scan(1'b0, -1, "stall5");
        check("stall5 done cycle", 64'(r_done_cyc), 64'(38));
        check_perf(1'b0, "stall5");

        // Grant held off three cycles on word 2.
        build(7, 14, 2, 1'b0, -1, 0, 2, 3);
        run_scan(1'b0, -1, "gntdly");
        check("gntdly done cycle",  64'(r_done_cyc), 64'(36));
        check("gntdly req cycles",  64'(r_req2),     64'(4));

        // Reset in a SHIFT cycle of word 2 (REQ 17, load 18, shifts 19..24).
        build(7, 14, 2, 1'b0, -1, 0, -1, 0);
        run_scan(1'b0, 20, "abort");
        rv = 1;
        @(negedge clk);
        sample(1'b0, ov, oa, orow, ocol);
        check("post-reset ctl", 64'(ov), 64'(0));
        check("post-reset addr/row/col", 64'({oa, orow, ocol}), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("stray rvalid load", 64'(a_load), 64'(0));
        @(posedge clk); #1;
        rv = 0;
        build(7, 14, 2, 1'b0, -1, 0, -1, 0);
        run_scan(1'b0, -1, "restart");
        check("restart done cycle", 64'(r_done_cyc), 64'(33));

        // Randomised delays, stalls, stray rvalid and start pulses while busy.
        for (int n = 0; n < 6; n++) begin
            build(7, 14, 2, 1'b1, -1, 0, -1, 0);
            run_scan(1'b0, -1, $sformatf("rand%0d", n));
            check($sformatf("rand%0d dones", n),     64'(r_dones),    64'(1));
            check($sformatf("rand%0d done cyc", n), 64'(r_done_cyc), 64'(end_c));
            check_perf(1'b0, $sformatf("rand%0d", n));
        end

        // One-pixel words: no shifting at all.
        build(1, 4, 1, 1'b0, -1, 0, -1, 0);
        run_scan(1'b1, -1, "wp1");
        check("wp1 done cycle", 64'(r_done_cyc), 64'(9));
        check("wp1 shifts",     64'(r_shifts),   64'(0));
        check("wp1 loads",      64'(r_loads),    64'(4));
        for (int n = 0; n < 3; n++) begin
            build(1, 4, 1, 1'b1, -1, 0, -1, 0);
            run_scan(1'b1, -1, $sformatf("wp1rand%0d", n));
            check($sformatf("wp1rand%0d dones", n), 64'(r_dones), 64'(1));
            check_perf(1'b1, $sformatf("wp1rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
